// File: rtl/text_char_streamer.sv
// Snapshots the finished custom-text buffer and streams it to the overlay one character per handshake.
// Optional TEXT_STREAM_UPPERCASE_EN folds lowercase ASCII to upper case on char_out.
module text_char_streamer #(
    parameter int TEXT_LEN_MAX = 20
) (
    input  logic                      clock_27mhz,
    input  logic                      reset,
    input  logic [TEXT_LEN_MAX*8-1:0] char_array,
    input  logic                      char_array_rdy,
    input  logic [5:0]                num_char,
    input  logic                      frame_start,
    input  logic                      char_ready,
    output logic                      char_valid,
    output logic [7:0]                char_out,
    output logic [5:0]                char_col,
    output logic                      char_last,
    output logic                      stream_done
);

    // state  | meaning
    // IDLE   | waiting for a rising edge of char_array_rdy
    // STREAM | presenting snapshot char idx until accepted
    // HOLD   | stream finished, snapshot kept for frame replays
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        HOLD   = 2'd2
    } state_t;

    localparam logic [5:0] LEN_MAX6 = 6'(TEXT_LEN_MAX);

    state_t                    state, state_next;
    logic                      rdy_prev;
    logic [TEXT_LEN_MAX*8-1:0] snapshot, snapshot_next;
    logic [5:0]                count, count_next;
    logic [5:0]                idx, idx_next;
    logic                      done_next;
    logic                      valid_next;
    logic [7:0]                out_next;
    logic [5:0]                col_next;
    logic                      last_next;
    logic [5:0]                count_clamped;
    logic                      rdy_rise;

    function automatic logic [7:0] pick_char(input logic [TEXT_LEN_MAX*8-1:0] arr,
                                             input logic [5:0] i);
        logic [7:0] b;
        b = '0;
        for (int k = 0; k < TEXT_LEN_MAX; k++) begin
            if (i == 6'(k)) b = arr[8*(TEXT_LEN_MAX-k)-1 -: 8];
        end
        return b;
    endfunction

    function automatic logic [7:0] fold_case(input logic [7:0] b);
`ifdef TEXT_STREAM_UPPERCASE_EN
        return (b >= 8'h61 && b <= 8'h7A) ? b - 8'h20 : b;
`else
        return b;
`endif
    endfunction

    assign rdy_rise      = char_array_rdy && !rdy_prev;
    assign count_clamped = (num_char > LEN_MAX6) ? LEN_MAX6 : num_char;

    always_comb begin
        state_next    = state;
        snapshot_next = snapshot;
        count_next    = count;
        idx_next      = idx;
        done_next     = 1'b0;
        case (state)
            IDLE: begin
                if (rdy_rise) begin
                    snapshot_next = char_array;
                    count_next    = count_clamped;
                    idx_next      = '0;
                    if (count_clamped == '0) begin
                        state_next = HOLD;
                        done_next  = 1'b1;
                    end else begin
                        state_next = STREAM;
                    end
                end
            end
            STREAM: begin
                // Dropping rdy abandons the stream without a done pulse.
                if (!char_array_rdy) begin
                    state_next = IDLE;
                end else if (char_ready) begin
                    if (idx == count - 6'd1) begin
                        state_next = HOLD;
                        done_next  = 1'b1;
                    end else begin
                        idx_next = idx + 6'd1;
                    end
                end
            end
            HOLD: begin
                if (!char_array_rdy) begin
                    state_next = IDLE;
                end else if (frame_start) begin
                    idx_next = '0;
                    if (count == '0) done_next = 1'b1;
                    else             state_next = STREAM;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs are registered from the next-state view so nothing combinational reaches the ports.
    always_comb begin
        valid_next = (state_next == STREAM);
        out_next   = '0;
        col_next   = '0;
        last_next  = 1'b0;
        if (valid_next) begin
            out_next  = fold_case(pick_char(snapshot_next, idx_next));
            col_next  = idx_next;
            last_next = (idx_next == count_next - 6'd1);
        end
    end

    always_ff @(posedge clock_27mhz) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clock_27mhz) begin
        if (reset) begin
            rdy_prev    <= 1'b0;
            snapshot    <= '0;
            count       <= '0;
            idx         <= '0;
            char_valid  <= 1'b0;
            char_out    <= '0;
            char_col    <= '0;
            char_last   <= 1'b0;
            stream_done <= 1'b0;
        end else begin
            rdy_prev    <= char_array_rdy;
            snapshot    <= snapshot_next;
            count       <= count_next;
            idx         <= idx_next;
            char_valid  <= valid_next;
            char_out    <= out_next;
            char_col    <= col_next;
            char_last   <= last_next;
            stream_done <= done_next;
        end
    end

endmodule

// File: tb/tb_text_char_streamer.sv
// Directed bench for text_char_streamer; expected values follow TEXT_STREAM_UPPERCASE_EN when defined.
module tb_text_char_streamer;

    localparam int TL = 20;

    logic          clock_27mhz = 1'b0;
    logic          reset;
    logic [TL*8-1:0] char_array;
    logic          char_array_rdy;
    logic [5:0]    num_char;
    logic          frame_start;
    logic          char_ready;
    logic          char_valid;
    logic [7:0]    char_out;
    logic [5:0]    char_col;
    logic          char_last;
    logic          stream_done;

    int num_checks = 0;
    int num_errors = 0;

    text_char_streamer #(.TEXT_LEN_MAX(TL)) dut (
        .clock_27mhz    (clock_27mhz),
        .reset          (reset),
        .char_array     (char_array),
        .char_array_rdy (char_array_rdy),
        .num_char       (num_char),
        .frame_start    (frame_start),
        .char_ready     (char_ready),
        .char_valid     (char_valid),
        .char_out       (char_out),
        .char_col       (char_col),
        .char_last      (char_last),
        .stream_done    (stream_done)
    );

    always #5 clock_27mhz = ~clock_27mhz;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        num_checks++;
        if (got !== exp) begin
            num_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock_27mhz);
        #1;
    endtask

    task automatic set_text(input string s);
        char_array = '0;
        for (int k = 0; k < s.len(); k++) char_array[8*(TL-k)-1 -: 8] = s[k];
    endtask

    task automatic expect_char(input string tag, input logic [7:0] b, input int col, input logic last);
        check({tag, "_valid"}, 32'(char_valid), 1);
        check({tag, "_out"},   32'(char_out),   32'(b));
        check({tag, "_col"},   32'(char_col),   32'(col));
        check({tag, "_last"},  32'(char_last),  32'(last));
        check({tag, "_done"},  32'(stream_done), 0);
        tick();
    endtask

    task automatic expect_done(input string tag);
        check({tag, "_done_valid"}, 32'(char_valid), 0);
        check({tag, "_done_hi"},    32'(stream_done), 1);
        tick();
        check({tag, "_done_lo"},    32'(stream_done), 0);
        check({tag, "_no_reload"},  32'(char_valid), 0);
    endtask

    // Drop rdy for one cycle, then raise it; outputs show char 0 after return.
    task automatic reload(input string s, input logic [5:0] n);
        char_array_rdy = 1'b0;
        tick();
        set_text(s);
        num_char       = n;
        char_array_rdy = 1'b1;
        tick();
    endtask

    function automatic logic [7:0] exp_fold(input logic [7:0] b);
`ifdef TEXT_STREAM_UPPERCASE_EN
        return (b >= 8'h61 && b <= 8'h7A) ? b - 8'h20 : b;
`else
        return b;
`endif
    endfunction

    initial begin
        logic [7:0] hi_bytes [3];
        logic       rpat [10];
        int         xfers;
        int         exp_idx;
        hi_bytes = '{8'h48, 8'h49, 8'h21};
        rpat     = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

        reset = 1'b1; char_array = '0; char_array_rdy = 1'b0; num_char = '0;
        frame_start = 1'b0; char_ready = 1'b1;
        tick(); tick();
        check("rst_valid", 32'(char_valid), 0);
        check("rst_out",   32'(char_out), 0);
        check("rst_col",   32'(char_col), 0);
        check("rst_last",  32'(char_last), 0);
        check("rst_done",  32'(stream_done), 0);
        reset = 1'b0;

        // "HI!" at full rate
        set_text("HI!"); num_char = 6'd3; char_array_rdy = 1'b1;
        tick();
        expect_char("hi0", 8'h48, 0, 1'b0);
        expect_char("hi1", 8'h49, 1, 1'b0);
        expect_char("hi2", 8'h21, 2, 1'b1);
        expect_done("hi");

        // replay from HOLD; frame_start is dropped after one sampled edge
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        expect_char("rp0", 8'h48, 0, 1'b0);
        frame_start = 1'b1;   // ignored while streaming
        expect_char("rp1", 8'h49, 1, 1'b0);
        frame_start = 1'b0;
        expect_char("rp2", 8'h21, 2, 1'b1);
        expect_done("rp");

        // backpressure
        reload("HI!", 6'd3);
        xfers = 0; exp_idx = 0;
        for (int c = 0; c < 10 && exp_idx < 3; c++) begin
            char_ready = rpat[c];
            check("bp_valid", 32'(char_valid), 1);
            check("bp_out",   32'(char_out), 32'(hi_bytes[exp_idx]));
            check("bp_col",   32'(char_col), 32'(exp_idx));
            check("bp_last",  32'(char_last), (exp_idx == 2) ? 1 : 0);
            tick();
            if (rpat[c]) begin
                xfers++;
                exp_idx++;
            end
        end
        check("bp_xfers", 32'(xfers), 3);
        char_ready = 1'b1;
        expect_done("bp");

        // empty text
        reload("", 6'd0);
        expect_done("empty");
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        expect_done("empty_rp");

        // count clamps to capacity
        begin
            string s20;
            s20 = "ABCDEFGHIJKLMNOPQRST";
            reload(s20, 6'd25);
            for (int k = 0; k < TL; k++) expect_char("clamp", s20[k], k, k == TL - 1);
            expect_done("clamp");
        end

        // abort after 2 of 5, then fresh "AB"
        reload("VWXYZ", 6'd5);
        expect_char("ab0", 8'h56, 0, 1'b0);
        expect_char("ab1", 8'h57, 1, 1'b0);
        check("ab2_pre", 32'(char_out), 32'h58);
        char_array_rdy = 1'b0;
        tick();
        check("abort_valid", 32'(char_valid), 0);
        check("abort_done",  32'(stream_done), 0);
        tick();
        check("abort_done2", 32'(stream_done), 0);
        set_text("AB"); num_char = 6'd2; char_array_rdy = 1'b1;
        tick();
        expect_char("new0", 8'h41, 0, 1'b0);
        expect_char("new1", 8'h42, 1, 1'b1);
        expect_done("new");

        // reset mid-stream
        reload("AB", 6'd2);
        check("mr_valid_pre", 32'(char_valid), 1);
        reset = 1'b1; char_array_rdy = 1'b0;
        tick();
        check("mr_valid", 32'(char_valid), 0);
        check("mr_out",   32'(char_out), 0);
        check("mr_col",   32'(char_col), 0);
        check("mr_last",  32'(char_last), 0);
        check("mr_done",  32'(stream_done), 0);
        reset = 1'b0;
        tick();

        // case folding
        reload("az{", 6'd3);
        expect_char("uc0", exp_fold(8'h61), 0, 1'b0);
        expect_char("uc1", exp_fold(8'h7A), 1, 1'b0);
        expect_char("uc2", 8'h7B, 2, 1'b1);
        expect_done("uc");

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule

// File: doc/text_char_streamer.md
# text_char_streamer

Reads the finished custom-text buffer (character array, character count, ready flag) produced by the keyboard text-entry block and streams it out one character per handshake to the text overlay / glyph renderer. First user character (leftmost byte) is emitted first. A snapshot is taken so the stream is stable while the entry side changes. The snapshot can be replayed on every video frame without re-entry.

## Interface

Parameters:
- TEXT_LEN_MAX, 20, character capacity of the array; must match the text-entry block (1..63).

Ports:
- clock_27mhz  in  1  system clock
- reset  in  1  synchronous, active-high
- char_array  in  TEXT_LEN_MAX*8  packed ASCII; char k (k=0 first) at bits [8*(TEXT_LEN_MAX-k)-1 -: 8]
- char_array_rdy  in  1  level; high = array and count final
- num_char  in  6  number of valid characters
- frame_start  in  1  one-cycle pulse; request a replay of the snapshot
- char_ready  in  1  renderer can accept a character
- char_valid  out  1  char_out/char_col/char_last valid
- char_out  out  8  ASCII byte
- char_col  out  6  column index of char_out (0-based)
- char_last  out  1  char_out is the final character
- stream_done  out  1  one-cycle pulse after the final character is accepted

## Operation

- States: IDLE, STREAM, HOLD.
- rdy_prev register tracks char_array_rdy (reset 0).
- IDLE: on a cycle with char_array_rdy=1 and rdy_prev=0:
  - Register snapshot <= char_array.
  - Register count <= min(num_char, TEXT_LEN_MAX).
  - idx <= 0.
  - If count would be 0: go to HOLD and pulse stream_done next cycle. Otherwise go to STREAM.
- STREAM:
  - char_valid=1.
  - char_out = snapshot char idx.
  - char_col = idx.
  - char_last = (idx == count-1).
  - Transfer occurs on a cycle with char_valid && char_ready. Then idx <= idx+1, or on the last transfer go to HOLD with stream_done=1 for exactly one cycle.
  - Outputs hold stable while char_ready=0.
- HOLD: snapshot retained.
  - frame_start=1 with char_array_rdy=1: idx <= 0; go to STREAM, or re-pulse stream_done if count=0.
  - char_array_rdy=0: go to IDLE.
- Abort: char_array_rdy=0 in STREAM goes to IDLE at that edge. The partial stream is not completed and no stream_done is produced.
- frame_start during STREAM is ignored.
- If a rising edge of char_array_rdy and frame_start coincide in IDLE, the rising edge wins (snapshot load).
- Reset (any state, mid-stream included) goes to IDLE.
  - char_valid=0, char_out=0, char_col=0, char_last=0, stream_done=0.
  - rdy_prev=0, snapshot=0, count=0, idx=0.
- idx/count are 6 bits. idx never exceeds count-1 in STREAM.

## Timing

- All outputs come from registers; there are no combinational paths from inputs to outputs.
- Latency to first character: char_valid rises 1 cycle after the cycle in which the char_array_rdy rising edge is sampled.
- Same 1-cycle latency from a frame_start sampled in HOLD.
- Throughput: 1 character/cycle with char_ready held high. An N-character stream occupies N consecutive char_valid cycles.
- stream_done is asserted in the cycle after the final transfer. char_valid is 0 in that cycle.
- Abort: char_valid is 0 in the cycle after char_array_rdy is sampled low.
- A re-raise of char_array_rdy needs it sampled low for ≥1 cycle first. Level-high with no edge never reloads.

## Configuration

- TEXT_STREAM_UPPERCASE_EN: the overlay font ROM holds only upper case, so lowercase is folded at the output.
  - Defined: char_out bytes 0x61–0x7A are emitted minus 0x20; all other bytes pass unchanged. The snapshot itself is unmodified.
  - Undefined: char_out is the raw snapshot byte.

## Test plan

- Load "HI!" (0x48,0x49,0x21), num_char=3, char_ready=1, raise rdy: expect
  - char_valid high for 3 consecutive cycles starting 1 cycle after the edge;
  - char_col 0,1,2;
  - char_last only on 0x21;
  - stream_done one cycle after that.
- Same load with char_ready toggling 1,0,0,1,...: each byte held stable while char_ready=0; exactly 3 transfers; order unchanged.
- num_char=0: no char_valid. stream_done pulses once. frame_start in HOLD re-pulses stream_done.
- num_char=25 with TEXT_LEN_MAX=20: exactly 20 transfers; char_last at col 19.
- Mid-stream drop of rdy after 2 of 5 transfers: char_valid=0 next cycle and no stream_done. Re-raise rdy with new array "AB": stream "A","B" from col 0. Assert reset mid-stream: all outputs 0 next cycle.
- frame_start in HOLD replays identical bytes/cols. With TEXT_STREAM_UPPERCASE_EN, "az{" streams 0x41,0x5A,0x7B; without it, 0x61,0x7A,0x7B.
